// File: rtl/uart_pkg.sv
// Frame constants and transmit state encoding shared by the UART transmitter and its receiver peer.
package uart_pkg;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_STOP_BITS = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // Index counters need at least one bit even when they only ever hold 0.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_tick_o on the last cycle.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic bit_tick_o
);

    localparam int CNT_W = idx_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_tick_o = en_i && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = bit_tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one byte per valid/ready handshake, start + LSB-first data + optional even parity + stop bits.
// Define UART_TX_PARITY_EN to include the parity bit in the frame and drive the parity port.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int STOP_BITS    = DEFAULT_STOP_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial,
    output logic                 busy,
    output logic                 parity
);

    localparam logic [2:0] IDLE   = TX_IDLE;
    localparam logic [2:0] START  = TX_START;
    localparam logic [2:0] DATA   = TX_DATA;
    localparam logic [2:0] PARITY = TX_PARITY;
    localparam logic [2:0] STOP   = TX_STOP;

    localparam int BIT_W  = idx_width(DATA_BITS);
    localparam int STOP_W = idx_width(STOP_BITS);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);

    logic [2:0]           state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [STOP_W-1:0]    stop_q, stop_d;
    logic                 parity_q, parity_d;
    logic                 serial_q, serial_d;
    logic                 bit_tick;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q == IDLE),
        .en_i      (state_q != IDLE),
        .bit_tick_o(bit_tick)
    );

    assign tx_ready = (state_q == IDLE);
    assign busy     = ~tx_ready;
    assign serial   = serial_q;
    assign parity   = parity_q;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        parity_d = parity_q;

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d = START;
                    shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`else
                    parity_d = 1'b0;
`endif
                end
            end
            START: begin
                if (bit_tick) state_d = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) state_d = STOP;
            end
            STOP: begin
                if (bit_tick) begin
                    if (stop_q == LAST_STOP) begin
                        stop_d  = '0;
                        state_d = IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line is registered from the next state so the start bit appears right after the handshake edge.
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = parity_d;
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            stop_q   <= '0;
            parity_q <= 1'b0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            parity_q <= parity_d;
            serial_q <= serial_d;
        end
    end

endmodule
